// File: rtl/opr_sequencer_pkg.sv
// rtl/opr_sequencer_pkg.sv - shared types and mode stepping for the operation sequencer
package opr_sequencer_pkg;

  typedef logic [15:0] word_t;

  // Mode encodings must stay contiguous from 0 so stepping can wrap arithmetically.
  localparam int OPR_MODE_COUNT = 6;

  typedef enum logic [2:0] {
    ADD   = 3'd0,
    SUB   = 3'd1,
    AND_M = 3'd2,
    OR_M  = 3'd3,
    XOR_M = 3'd4,
    SHL   = 3'd5
  } opr_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SHOW
  } seq_state_t;

  localparam logic [2:0] MODE_LAST = 3'(OPR_MODE_COUNT - 1);

  function automatic opr_mode_t step_mode(input opr_mode_t m, input logic up);
    if (up)
      return (m == opr_mode_t'(MODE_LAST)) ? ADD : opr_mode_t'(m + 3'd1);
    else
      return (m == ADD) ? opr_mode_t'(MODE_LAST) : opr_mode_t'(m - 3'd1);
  endfunction

endpackage

// File: rtl/opr_sequencer_if.sv
// rtl/opr_sequencer_if.sv - sequencer to datapath connection
interface opr_sequencer_if;
  import opr_sequencer_pkg::*;

  opr_mode_t selector;
  word_t     operand;
  word_t     result_in;

  modport master (output selector, output operand, input result_in);
  modport slave  (input selector, input operand, output result_in);
endinterface

// File: rtl/opr_sequencer_btn_debounce.sv
// rtl/opr_sequencer_btn_debounce.sv - push-button synchronizer, debouncer and press pulse
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // A change is only accepted after the synchronized input has disagreed for a full run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b00;
      cnt   <= '0;
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[0], raw};
      press <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt   <= '0;
        level <= sync[1];
        press <= sync[1];
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/opr_sequencer.sv
// rtl/opr_sequencer.sv - button-driven controller for the 16-bit operation datapath
module opr_sequencer
  import opr_sequencer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SETTLE_CYCLES   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    btnc_raw,
  input  logic                    btnu_raw,
  input  logic                    btnd_raw,
  input  logic                    btnl_raw,
  input  logic                    btnr_raw,
  input  word_t                   sw,
  opr_sequencer_if.master         dp,
  output word_t                   led,
  output logic                    busy
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  logic [4:0] btn_level;
  logic       press_c, press_u, press_d, press_l, press_r;
  logic       p_c, p_u, p_d, p_l, p_r;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnc (.clk(clk), .rst(rst), .raw(btnc_raw), .level(btn_level[0]), .press(press_c));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnu (.clk(clk), .rst(rst), .raw(btnu_raw), .level(btn_level[1]), .press(press_u));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnd (.clk(clk), .rst(rst), .raw(btnd_raw), .level(btn_level[2]), .press(press_d));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnl (.clk(clk), .rst(rst), .raw(btnl_raw), .level(btn_level[3]), .press(press_l));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btnr (.clk(clk), .rst(rst), .raw(btnr_raw), .level(btn_level[4]), .press(press_r));

  // Only the highest-priority pulse of a cycle survives: r > c > u > d > l.
  assign p_r = press_r;
  assign p_c = press_c & ~p_r;
  assign p_u = press_u & ~p_r & ~press_c;
  assign p_d = press_d & ~p_r & ~press_c & ~press_u;
  assign p_l = press_l & ~p_r & ~press_c & ~press_u & ~press_d;

  seq_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  opr_mode_t        selector_q, selector_d;
  word_t            operand_q, operand_d;
  word_t            result_q, result_d;
  logic             show_q, show_d;
  word_t            led_d;
  logic             busy_d;

  assign dp.selector = selector_q;
  assign dp.operand  = operand_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      selector_q <= ADD;
      operand_q  <= '0;
      result_q   <= '0;
      show_q     <= 1'b0;
      led        <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      selector_q <= selector_d;
      operand_q  <= operand_d;
      result_q   <= result_d;
      show_q     <= show_d;
      led        <= led_d;
      busy       <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    selector_d = selector_q;
    operand_d  = operand_q;
    result_d   = result_q;
    show_d     = show_q;
    led_d      = led;
    unique case (state_q)
      IDLE: begin
        led_d = dp.result_in;
        if (p_c) begin
          operand_d = sw;
          state_d   = SETTLE;
          cnt_d     = CNT_W'(SETTLE_CYCLES - 1);
        end else if (p_u || p_d) begin
          selector_d = step_mode(selector_q, p_u);
        end
      end
      SETTLE: begin
        if (p_r) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          result_d = dp.result_in;
          state_d  = SHOW;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SHOW: begin
        led_d = show_q ? operand_q : result_q;
        if (p_r) begin
          result_d = '0;
          show_d   = 1'b0;
          state_d  = IDLE;
        end else if (p_c || p_u || p_d) begin
          // A mode step re-evaluates the same operand through another settle pass.
          if (p_c) operand_d = sw;
          else     selector_d = step_mode(selector_q, p_u);
          state_d = SETTLE;
          cnt_d   = CNT_W'(SETTLE_CYCLES - 1);
        end else if (p_l) begin
          show_d = ~show_q;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SETTLE);
  end
endmodule

// File: tb/tb_opr_sequencer.sv
// tb/tb_opr_sequencer.sv - self-checking bench for opr_sequencer with a transaction-level model
module tb_opr_sequencer;
  import opr_sequencer_pkg::*;

  localparam int DEB = 4;
  localparam int SET = 3;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  btnc_raw = 1'b0, btnu_raw = 1'b0, btnd_raw = 1'b0, btnl_raw = 1'b0, btnr_raw = 1'b0;
  word_t sw = '0;
  word_t led;
  logic  busy;

  opr_sequencer_if dp();
  assign dp.result_in = dp.operand + 16'(dp.selector);

  opr_sequencer #(.DEBOUNCE_CYCLES(DEB), .SETTLE_CYCLES(SET)) dut (
    .clk(clk), .rst(rst),
    .btnc_raw(btnc_raw), .btnu_raw(btnu_raw), .btnd_raw(btnd_raw),
    .btnl_raw(btnl_raw), .btnr_raw(btnr_raw),
    .sw(sw), .dp(dp), .led(led), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: what the board shows after each button transaction has fully settled.
  int    m_sel;
  word_t m_op, m_res;
  bit    m_show, m_in_show;

  function automatic void model_reset();
    m_sel = 0; m_op = '0; m_res = '0; m_show = 0; m_in_show = 0;
  endfunction

  function automatic word_t exp_led();
    if (m_in_show) return m_show ? m_op : m_res;
    return m_op + 16'(m_sel);
  endfunction

  // b: 0=centre 1=up 2=down 3=left 4=right
  function automatic void model_apply(input int b, input word_t swv);
    case (b)
      0: begin m_op = swv; m_res = m_op + 16'(m_sel); m_in_show = 1; end
      1, 2: begin
        m_sel = (m_sel + ((b == 1) ? 1 : OPR_MODE_COUNT - 1)) % OPR_MODE_COUNT;
        if (m_in_show) m_res = m_op + 16'(m_sel);
      end
      3: if (m_in_show) m_show = !m_show;
      default: if (m_in_show) begin m_res = '0; m_show = 0; m_in_show = 0; end
    endcase
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input bit [4:0] m);
    btnc_raw = m[0]; btnu_raw = m[1]; btnd_raw = m[2]; btnl_raw = m[3]; btnr_raw = m[4];
  endtask

  // Press the m0 buttons, add the m1 buttons one cycle later, then release all.
  task automatic press(input bit [4:0] m0, input bit [4:0] m1, output int busy_cnt);
    busy_cnt = 0;
    drive(m0);
    @(negedge clk); busy_cnt += int'(busy);
    drive(m0 | m1);
    repeat (14) begin @(negedge clk); busy_cnt += int'(busy); end
    drive(5'b0);
    repeat (14) begin @(negedge clk); busy_cnt += int'(busy); end
  endtask

  task automatic test_reset();
    int waited;
    rst = 1'b1; tick(3); rst = 1'b0; tick(2);
    model_reset();
    n_tests++; if (dp.selector !== ADD) begin n_fail++; $display("FAIL reset_selector got %0d want 0", dp.selector); end
    n_tests++; if (dp.operand !== 16'h0) begin n_fail++; $display("FAIL reset_operand got %h want 0000", dp.operand); end
    n_tests++; if (led !== 16'h0) begin n_fail++; $display("FAIL reset_led got %h want 0000", led); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    sw = 16'($urandom) | 16'h0001;
    btnc_raw = 1'b1;
    waited = 0;
    while (busy !== 1'b1 && waited < 30) begin @(negedge clk); waited++; end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_reach_settle got busy=%b want 1", busy); end
    btnc_raw = 1'b0;
    #2 rst = 1'b1; #1 rst = 1'b0; #1;
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL midreset_state got %0d want IDLE", dut.state_q); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy got %b want 0", busy); end
    n_tests++; if (dp.operand !== 16'h0 || dp.selector !== ADD || led !== 16'h0) begin
      n_fail++; $display("FAIL midreset_regs got op=%h sel=%0d led=%h want 0/0/0", dp.operand, dp.selector, led); end
    tick(20);
    n_tests++; if (dut.state_q !== IDLE || dut.result_q !== 16'h0) begin
      n_fail++; $display("FAIL midreset_no_sample got state=%0d res=%h want IDLE/0000", dut.state_q, dut.result_q); end
  endtask

  task automatic test_run_bounce();
    int pulses, bcnt, fell, i;
    bit prev;
    word_t led_at;
    pulses = 0; bcnt = 0; fell = -1; prev = 0; led_at = 16'hDEAD; i = 0;
    sw = 16'h00A5;
    btnc_raw = 1'b1; @(negedge clk); pulses += int'(dut.u_btnc.press); bcnt += int'(busy);
    btnc_raw = 1'b0; @(negedge clk); pulses += int'(dut.u_btnc.press); bcnt += int'(busy);
    btnc_raw = 1'b1;
    repeat (20) begin
      @(negedge clk);
      pulses += int'(dut.u_btnc.press); bcnt += int'(busy);
      if (prev && !busy && fell < 0) fell = i;
      if (fell >= 0 && i == fell + 1) led_at = led;
      prev = busy; i++;
    end
    btnc_raw = 1'b0; tick(14);
    model_apply(0, 16'h00A5);
    n_tests++; if (pulses !== 1) begin n_fail++; $display("FAIL bounce_pulses got %0d want 1", pulses); end
    n_tests++; if (bcnt !== SET) begin n_fail++; $display("FAIL run_busy_cycles got %0d want %0d", bcnt, SET); end
    n_tests++; if (dp.operand !== 16'h00A5) begin n_fail++; $display("FAIL run_operand got %h want 00a5", dp.operand); end
    n_tests++; if (led_at !== 16'h00A5) begin n_fail++; $display("FAIL run_led_after_settle got %h want 00a5", led_at); end
  endtask

  task automatic test_mode_step();
    int bc;
    press(5'b10000, 5'b0, bc); model_apply(4, sw);
    n_tests++; if (dut.state_q !== IDLE) begin n_fail++; $display("FAIL clear_to_idle got %0d want IDLE", dut.state_q); end
    press(5'b00100, 5'b0, bc); model_apply(2, sw);
    n_tests++; if (dp.selector !== opr_mode_t'(OPR_MODE_COUNT - 1)) begin n_fail++; $display("FAIL step_down_wrap got %0d want %0d", dp.selector, OPR_MODE_COUNT - 1); end
    n_tests++; if (led !== exp_led()) begin n_fail++; $display("FAIL idle_live_led got %h want %h", led, exp_led()); end
    press(5'b00010, 5'b0, bc); model_apply(1, sw);
    n_tests++; if (dp.selector !== ADD) begin n_fail++; $display("FAIL step_up_wrap got %0d want 0", dp.selector); end
    for (int k = 0; k < OPR_MODE_COUNT; k++) begin press(5'b00010, 5'b0, bc); model_apply(1, sw); end
    n_tests++; if (dp.selector !== ADD || m_sel != 0) begin n_fail++; $display("FAIL step_full_cycle got %0d want 0", dp.selector); end
  endtask

  task automatic test_show_display();
    int bc;
    sw = 16'($urandom);
    press(5'b00001, 5'b0, bc); model_apply(0, sw);
    n_tests++; if (led !== exp_led()) begin n_fail++; $display("FAIL show_result got %h want %h", led, exp_led()); end
    sw = 16'hFFFF; tick(10);
    n_tests++; if (led !== exp_led() || dp.operand !== m_op) begin
      n_fail++; $display("FAIL sw_no_capture got led=%h op=%h want %h/%h", led, dp.operand, exp_led(), m_op); end
    press(5'b01000, 5'b0, bc); model_apply(3, sw);
    n_tests++; if (led !== m_op) begin n_fail++; $display("FAIL show_operand got %h want %h", led, m_op); end
    press(5'b01000, 5'b0, bc); model_apply(3, sw);
    n_tests++; if (led !== m_res) begin n_fail++; $display("FAIL show_result_again got %h want %h", led, m_res); end
  endtask

  task automatic test_show_step();
    int bc;
    press(5'b00010, 5'b0, bc); model_apply(1, sw);
    n_tests++; if (bc !== SET) begin n_fail++; $display("FAIL reeval_busy got %0d want %0d", bc, SET); end
    n_tests++; if (led !== exp_led()) begin n_fail++; $display("FAIL reeval_led got %h want %h", led, exp_led()); end
    press(5'b00110, 5'b0, bc); model_apply(1, sw);
    n_tests++; if (dp.selector !== opr_mode_t'(m_sel) || led !== exp_led()) begin
      n_fail++; $display("FAIL up_over_down got sel=%0d led=%h want %0d/%h", dp.selector, led, m_sel, exp_led()); end
  endtask

  task automatic test_settle_ignore();
    int bc;
    sw = m_op ^ 16'h5A5A;
    press(5'b00010, 5'b00101, bc); model_apply(1, sw);
    n_tests++; if (dp.operand !== m_op || dp.selector !== opr_mode_t'(m_sel)) begin
      n_fail++; $display("FAIL settle_ignore got op=%h sel=%0d want %h/%0d", dp.operand, dp.selector, m_op, m_sel); end
    n_tests++; if (bc !== SET || led !== exp_led()) begin
      n_fail++; $display("FAIL settle_ignore_run got busy=%0d led=%h want %0d/%h", bc, led, SET, exp_led()); end
    press(5'b00010, 5'b10000, bc);
    m_sel = (m_sel + 1) % OPR_MODE_COUNT; m_in_show = 0;
    n_tests++; if (dut.state_q !== IDLE || bc !== 1) begin
      n_fail++; $display("FAIL settle_abort got state=%0d busy=%0d want IDLE/1", dut.state_q, bc); end
    n_tests++; if (dut.result_q !== m_res || led !== exp_led()) begin
      n_fail++; $display("FAIL abort_no_sample got res=%h led=%h want %h/%h", dut.result_q, led, m_res, exp_led()); end
    sw = 16'($urandom);
    press(5'b00001, 5'b0, bc); model_apply(0, sw);
    press(5'b10000, 5'b0, bc); model_apply(4, sw);
    n_tests++; if (dut.result_q !== 16'h0 || dp.operand !== m_op || dp.selector !== opr_mode_t'(m_sel)) begin
      n_fail++; $display("FAIL show_clear got res=%h op=%h sel=%0d want 0000/%h/%0d", dut.result_q, dp.operand, dp.selector, m_op, m_sel); end
  endtask

  task automatic test_random();
    int b, bc, exp_bc;
    word_t swv;
    for (int k = 0; k < 20; k++) begin
      b = int'($urandom_range(0, 4));
      swv = 16'($urandom);
      sw = swv;
      exp_bc = (b == 0 || ((b == 1 || b == 2) && m_in_show)) ? SET : 0;
      press(5'(1 << b), 5'b0, bc);
      model_apply(b, swv);
      n_tests++; if (led !== exp_led() || dp.selector !== opr_mode_t'(m_sel) || dp.operand !== m_op || bc !== exp_bc) begin
        n_fail++; $display("FAIL random_%0d btn=%0d got led=%h sel=%0d op=%h busy=%0d want %h/%0d/%h/%0d",
                           k, b, led, dp.selector, dp.operand, bc, exp_led(), m_sel, m_op, exp_bc); end
    end
  endtask

  initial begin
    test_reset();
    test_run_bounce();
    test_mode_step();
    test_show_display();
    test_show_step();
    test_settle_ignore();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/opr_sequencer.md
Name: opr_sequencer

Overview:
Button-driven controller for the board's 16-bit operation datapath, which computes a result from an operand and an opr_mode_t selector.
- Owns the selector register and the operand register that drive the datapath.
- Debounces the five push buttons.
- After a settle interval, samples the datapath result into a hold register for LED display.
- Sits between the board I/O (SW, BTNx, LED) and the datapath instance.

Parameters:
DEBOUNCE_CYCLES, 16'd50000, consecutive stable synchronized cycles required to accept a button level change.
SETTLE_CYCLES, 4, cycles between driving a new operand/selector and sampling result_in (min 1).

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btnc_raw  in  1  centre button, async; run
btnu_raw  in  1  up button, async; next mode
btnd_raw  in  1  down button, async; previous mode
btnl_raw  in  1  left button, async; toggle display source
btnr_raw  in  1  right button, async; clear
sw  in  word_t  switch word
result_in  in  word_t  datapath result
selector  out  opr_mode_t  datapath mode select
operand  out  word_t  datapath operand
led  out  word_t  LED display
busy  out  1  high in SETTLE

Behaviour:
- Reset values: selector=ADD (encoding 0), operand=0, result_q=0, led=0, busy=0, state=IDLE, show_operand=0, all debouncers released. Reset asserted mid-SETTLE aborts immediately; no sample is taken.
- Button path (per button):
  - 2-FF synchronizer, then debounce counter.
  - A level change is accepted only after the synchronized level differs from the accepted level for DEBOUNCE_CYCLES consecutive cycles. Any glitch restarts the count.
  - A 1-cycle press pulse fires on the accepted rising edge only. Holding a button yields exactly one pulse.
- Same-cycle pulse priority: btnr > btnc > btnu > btnd > btnl. Lower-priority pulses in that cycle are dropped.
- Mode stepping:
  - btnu: selector+1, wrapping OPR_MODE_COUNT-1 -> 0.
  - btnd: selector-1, wrapping 0 -> OPR_MODE_COUNT-1.
- FSM states: IDLE, SETTLE, SHOW.
- IDLE:
  - led = result_in (live).
  - btnc: operand<=sw; go to SETTLE with cnt=SETTLE_CYCLES-1.
  - btnu/btnd: step selector; stay in IDLE.
  - btnl, btnr: no effect.
- SETTLE:
  - busy=1; led holds its previous value.
  - Each cycle: cnt decrements. At cnt==0: result_q<=result_in, go to SHOW.
  - Latency: SETTLE_CYCLES cycles from the cycle after btnc is accepted to the result_q update.
  - btnc/btnu/btnd/btnl ignored. btnr aborts to IDLE.
- SHOW:
  - led = show_operand ? operand : result_q (registered).
  - btnl toggles show_operand.
  - btnu/btnd: step selector and re-enter SETTLE with the same operand (auto re-evaluate).
  - btnc: operand<=sw; re-enter SETTLE.
  - btnr: result_q<=0, show_operand<=0, go to IDLE. Operand and selector are kept.
- Outputs are registered; led is updated one cycle after the state/source change.
- sw changes outside a btnc capture never affect operand.

Decomposition:
- types_pkg additions:
  - OPR_MODE_COUNT constant; opr_mode_t encoding must stay contiguous 0..OPR_MODE_COUNT-1.
  - seq_state_t enum {IDLE, SETTLE, SHOW}.
  - Reuse word_t.
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst, raw, level, press), instantiated five times.
- Top-level holds the FSM, the registers and the priority logic.

Test Plan (DEBOUNCE_CYCLES=4, SETTLE_CYCLES=3, datapath stub result_in = operand + selector):
1. Reset release -> selector=ADD, operand=0, led=0, busy=0.
   - Raise rst for 1 ns during SETTLE -> same values, state=IDLE immediately.
2. btnc_raw bouncing 1-0-1 at 1-cycle intervals, then held high 20 cycles -> exactly one press pulse.
   - sw=16'h00A5 -> operand=16'h00A5.
   - busy high exactly 3 cycles.
   - led=16'h00A5 one cycle after SETTLE exits.
3. From IDLE at ADD, press btnd -> selector=OPR_MODE_COUNT-1.
   - Press btnu -> selector=ADD.
   - Press btnu OPR_MODE_COUNT times -> selector=ADD (wrap).
4. In SHOW, change sw to 16'hFFFF without btnc -> led unchanged.
   - btnl -> led=operand.
   - btnl again -> led=result_q.
5. In SHOW, press btnu -> busy for 3 cycles, then led=operand+1.
   - btnu and btnd pulses in the same cycle -> only btnu applied.
6. During SETTLE, btnc ignored.
   - btnr -> IDLE, no result_q update.
   - In SHOW, btnr -> result_q=0, selector and operand retained.
